// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data-memory responder with wait states and valid/ready handshakes
// Optional build macro DMEM_BYTE_STROBE_EN adds req_be[3:0] per-byte store enables.
module data_mem_responder #(
  parameter int          DATA_MEMORY_DEPTH = 128,
  parameter int          WAIT_STATES       = 2,
  parameter logic [31:0] BASE_ADDR         = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  lat_be;
  logic [3:0]  acc_be;
`endif

  logic [31:0] mem [DATA_MEMORY_DEPTH];

  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [29:0] acc_word;
  logic [IW-1:0] acc_idx;
  logic        acc_fault;
  logic        do_access;

  // With zero wait states the access happens on the accept edge, so it must see the live request.
  always_comb begin
    acc_write = (state == IDLE) ? req_write : lat_write;
    acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
`ifdef DMEM_BYTE_STROBE_EN
    acc_be    = (state == IDLE) ? req_be    : lat_be;
`endif
    acc_word  = acc_addr[31:2] - BASE_ADDR[31:2];
    acc_idx   = acc_word[IW-1:0];
    acc_fault = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                (acc_word >= 30'(DATA_MEMORY_DEPTH));
    do_access = reset && (((state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                          ((state == WAIT) && (cnt == 4'd0)));
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_access && acc_write && !acc_fault) begin
`ifdef DMEM_BYTE_STROBE_EN
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
`else
      mem[acc_idx] <= acc_wdata;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
      lat_be     <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
            lat_be    <= req_be;
`endif
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          // resp_valid lags RESP entry by one cycle so the response is a registered output.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (do_access) begin
        resp_err   <= acc_fault;
        resp_rdata <= (!acc_write && !acc_fault) ? mem[acc_idx] : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed vector bench for data_mem_responder (WAIT_STATES=2 and 0)
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_resp_valid, z_resp_ready, z_resp_err;
  logic [31:0] z_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_STATES(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(req_be),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(z_req_be),
`endif
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input string name, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] er, input logic ee, input int hold);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~w; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF; req_be = 4'h0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({name, " latency"}, 32'(n), 32'd3);
    chk({name, " rdata"}, resp_rdata, er);
    chk({name, " err"}, 32'(resp_err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, " hold valid"}, 32'(resp_valid), 32'd1);
      chk({name, " hold req_ready"}, 32'(req_ready), 32'd0);
      chk({name, " hold rdata"}, resp_rdata, er);
      chk({name, " hold err"}, 32'(resp_err), 32'(ee));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({name, " valid drop"}, 32'(resp_valid), 32'd0);
    chk({name, " idle ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic txn0(input string name, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er);
    int n;
    z_req_valid = 1'b1; z_req_write = w; z_req_addr = a; z_req_wdata = d; z_req_be = 4'hF;
    @(posedge clk); #1;
    z_req_valid = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0;
    n = 0;
    while (!z_resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({name, " latency"}, 32'(n), 32'd1);
    chk({name, " rdata"}, z_resp_rdata, er);
    z_resp_ready = 1'b1;
    @(posedge clk); #1;
    z_resp_ready = 1'b0;
    chk({name, " valid drop"}, 32'(z_resp_valid), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, 32'h1001_0000, 32'h0BAD_F00D, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h1001_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b0, 32'h1001_0002, 32'h0,         32'h0,         1'b1};
    vecs[4]  = '{1'b0, 32'h1001_0200, 32'h0,         32'h0,         1'b1};
    vecs[5]  = '{1'b1, 32'h1001_0001, 32'h5555_5555, 32'h0,         1'b1};
    vecs[6]  = '{1'b0, 32'h1001_0000, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[7]  = '{1'b0, 32'h1000_FFFC, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'h1001_01FC, 32'hCAFE_BABE, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'h1001_01FC, 32'h0,         32'hCAFE_BABE, 1'b0};
    vecs[10] = '{1'b1, 32'h1001_0010, 32'h0F0F_0F0F, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'h1001_0010, 32'h0,         32'h0F0F_0F0F, 1'b0};

    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'hF;
    resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0; z_req_be = 4'hF;
    z_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, 4'hF, vecs[i].er, vecs[i].ee, 0);

    txn("stall store", 1'b1, 32'h1001_0004, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 5);
    txn("stall load", 1'b0, 32'h1001_0004, 32'h0, 4'hF, 32'h1111_1111, 1'b0, 2);

    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1001_0010; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort resp_valid", 32'(resp_valid), 32'd0);
    chk("abort resp_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    txn("after abort", 1'b0, 32'h1001_0010, 32'h0, 4'hF, 32'h0F0F_0F0F, 1'b0, 0);

    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1001_0014; req_wdata = 32'h7777_7777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("resp-reset latency", 32'(n), 32'd3);
    reset = 1'b0;
    #1;
    chk("resp-reset valid", 32'(resp_valid), 32'd0);
    chk("resp-reset req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    txn("committed", 1'b0, 32'h1001_0014, 32'h0, 4'hF, 32'h7777_7777, 1'b0, 0);

    txn0("ws0 store", 1'b1, 32'h1001_0020, 32'hA5A5_A5A5, 32'h0);
    txn0("ws0 load", 1'b0, 32'h1001_0020, 32'h0, 32'hA5A5_A5A5);

`ifdef DMEM_BYTE_STROBE_EN
    txn("be full", 1'b1, 32'h1001_0018, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0, 0);
    txn("be 0101", 1'b1, 32'h1001_0018, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 0);
    txn("be load", 1'b0, 32'h1001_0018, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0, 0);
    txn("be none", 1'b1, 32'h1001_0018, 32'h0, 4'b0000, 32'h0, 1'b0, 0);
    txn("be load2", 1'b0, 32'h1001_0018, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
